// File: rtl/pacman_move_scheduler_if.sv
// Bundles the request, wall-map port and movement status signals of the move scheduler.
// Latency: none, wiring only.
// Backpressure: none; the scheduler owns map_rd and expects map_wall one cycle later.
interface pacman_move_scheduler_if #(
    parameter int X_W = 5,
    parameter int Y_W = 5
);
    logic           run;
    logic           up_req;
    logic           down_req;
    logic           left_req;
    logic           right_req;
    logic           map_rd;
    logic [X_W-1:0] map_x;
    logic [Y_W-1:0] map_y;
    logic           map_wall;
    logic [X_W-1:0] pos_x;
    logic [Y_W-1:0] pos_y;
    logic [3:0]     cur_dir;
    logic           moved;
    logic           blocked;

    // Scheduler side
    modport master (
        input  run, up_req, down_req, left_req, right_req, map_wall,
        output map_rd, map_x, map_y, pos_x, pos_y, cur_dir, moved, blocked
    );

    // Game / maze-memory side
    modport slave (
        output run, up_req, down_req, left_req, right_req, map_wall,
        input  map_rd, map_x, map_y, pos_x, pos_y, cur_dir, moved, blocked
    );
endinterface

// File: rtl/pacman_move_scheduler.sv
// Steps Pac-Man one tile per movement tick: try the held turn, else keep going, else stop.
// Latency: tick to moved is 3 cycles, or 5 when a failed turn falls back to a straight move.
// Backpressure: none; wall map is a shared sync-read port. Optional TUNNEL_WRAP_EN wraps x at the edges.
module pacman_move_scheduler #(
    parameter int GRID_W   = 28,
    parameter int GRID_H   = 31,
    parameter int START_X  = 14,
    parameter int START_Y  = 23,
    parameter int MOVE_DIV = 8,
    parameter int X_W      = $clog2(GRID_W),
    parameter int Y_W      = $clog2(GRID_H)
) (
    input  logic                   clk,
    input  logic                   reset,
    pacman_move_scheduler_if.master bus
);
    localparam int              CNT_W    = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOVE_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [X_W-1:0]   X_MAX    = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0]   Y_MAX    = Y_W'(GRID_H - 1);
    localparam logic [X_W-1:0]   X_ONE    = X_W'(1);
    localparam logic [Y_W-1:0]   Y_ONE    = Y_W'(1);
    localparam logic [3:0]       DIR_UP   = 4'b1000;
    localparam logic [3:0]       DIR_DN   = 4'b0100;
    localparam logic [3:0]       DIR_LT   = 4'b0010;
    localparam logic [3:0]       DIR_RT   = 4'b0001;

    typedef enum logic [2:0] {S_IDLE, S_Q_REQ, S_R_REQ, S_Q_CUR, S_R_CUR} state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_tick_pend;
    logic [X_W-1:0]   r_pos_x, r_map_x, w_nb_x;
    logic [Y_W-1:0]   r_pos_y, r_map_y, w_nb_y;
    logic [3:0]       r_cur_dir, r_qry_dir, w_issue_dir, w_req;
    logic             r_moved, r_blocked, r_map_rd, r_oob;
    logic             w_req_vld, w_wall, w_nb_oob, w_issue, w_pend_clr, w_move, w_take_req, w_blk_set;

    // A request only counts when exactly one direction is held.
    assign w_req     = {bus.up_req, bus.down_req, bus.left_req, bus.right_req};
    assign w_req_vld = (w_req != 4'd0) && ((w_req & (w_req - 4'd1)) == 4'd0);
    // Off-grid targets were never read and count as walls in the response slot.
    assign w_wall    = r_oob | bus.map_wall;

    // Movement tick divider; a pending tick is dropped whenever the game is paused.
    always_ff @(posedge clk) begin
        if (reset || !bus.run) begin
            r_cnt       <= '0;
            r_tick_pend <= 1'b0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt       <= '0;
            r_tick_pend <= 1'b1;
        end else begin
            r_cnt <= r_cnt + CNT_ONE;
            if (w_pend_clr) r_tick_pend <= 1'b0;
        end
    end

    // Neighbour tile of the current position in the direction about to be queried.
    always_comb begin
        w_nb_x   = r_pos_x;
        w_nb_y   = r_pos_y;
        w_nb_oob = 1'b1;
        case (w_issue_dir)
            DIR_UP: if (r_pos_y != '0) begin
                w_nb_oob = 1'b0;
                w_nb_y   = r_pos_y - Y_ONE;
            end
            DIR_DN: if (r_pos_y != Y_MAX) begin
                w_nb_oob = 1'b0;
                w_nb_y   = r_pos_y + Y_ONE;
            end
            DIR_LT: if (r_pos_x != '0) begin
                w_nb_oob = 1'b0;
                w_nb_x   = r_pos_x - X_ONE;
            end else begin
`ifdef TUNNEL_WRAP_EN
                w_nb_oob = 1'b0;
                w_nb_x   = X_MAX;
`endif
            end
            DIR_RT: if (r_pos_x != X_MAX) begin
                w_nb_oob = 1'b0;
                w_nb_x   = r_pos_x + X_ONE;
            end else begin
`ifdef TUNNEL_WRAP_EN
                w_nb_oob = 1'b0;
                w_nb_x   = '0;
`endif
            end
            default: w_nb_oob = 1'b1;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // FSM next state and per-cycle actions; pausing aborts any in-flight query.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_issue_dir = r_cur_dir;
        w_pend_clr  = 1'b0;
        w_move      = 1'b0;
        w_take_req  = 1'b0;
        w_blk_set   = 1'b0;
        if (!bus.run) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (r_tick_pend) begin
                    w_pend_clr = 1'b1;
                    if (w_req_vld && (w_req != r_cur_dir)) begin
                        w_state_nxt = S_Q_REQ;
                        w_issue     = 1'b1;
                        w_issue_dir = w_req;
                    end else if (r_cur_dir != 4'd0) begin
                        w_state_nxt = S_Q_CUR;
                        w_issue     = 1'b1;
                    end
                end
                S_Q_REQ: w_state_nxt = S_R_REQ;
                S_R_REQ: begin
                    w_state_nxt = S_IDLE;
                    if (!w_wall) begin
                        w_move     = 1'b1;
                        w_take_req = 1'b1;
                    end else if (r_cur_dir != 4'd0) begin
                        w_state_nxt = S_Q_CUR;
                        w_issue     = 1'b1;
                    end else begin
                        w_blk_set = 1'b1;
                    end
                end
                S_Q_CUR: w_state_nxt = S_R_CUR;
                S_R_CUR: begin
                    w_state_nxt = S_IDLE;
                    if (!w_wall) w_move    = 1'b1;
                    else         w_blk_set = 1'b1;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Query port, position, facing and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pos_x   <= X_W'(START_X);
            r_pos_y   <= Y_W'(START_Y);
            r_cur_dir <= 4'd0;
            r_qry_dir <= 4'd0;
            r_moved   <= 1'b0;
            r_blocked <= 1'b0;
            r_map_rd  <= 1'b0;
            r_map_x   <= '0;
            r_map_y   <= '0;
            r_oob     <= 1'b0;
        end else begin
            r_moved  <= w_move;
            r_map_rd <= w_issue & ~w_nb_oob;
            if (w_issue) begin
                r_oob     <= w_nb_oob;
                r_qry_dir <= w_issue_dir;
                if (!w_nb_oob) begin
                    r_map_x <= w_nb_x;
                    r_map_y <= w_nb_y;
                end
            end
            // A successful query always came from an on-grid (or wrapped) tile held in map_x/y.
            if (w_move) begin
                r_pos_x   <= r_map_x;
                r_pos_y   <= r_map_y;
                r_blocked <= 1'b0;
            end
            if (w_take_req) r_cur_dir <= r_qry_dir;
            if (w_blk_set)  r_blocked <= 1'b1;
        end
    end

    assign bus.map_rd  = r_map_rd;
    assign bus.map_x   = r_map_x;
    assign bus.map_y   = r_map_y;
    assign bus.pos_x   = r_pos_x;
    assign bus.pos_y   = r_pos_y;
    assign bus.cur_dir = r_cur_dir;
    assign bus.moved   = r_moved;
    assign bus.blocked = r_blocked;
endmodule

// File: tb/tb_pacman_move_scheduler.sv
// Bench for pacman_move_scheduler: tile-level movement model plus directed scenarios.
// Latency: model results land 3 or 5 cycles after each tick.
// Backpressure: none; the bench plays the synchronous wall-map memory.
module tb_pacman_move_scheduler;
    localparam int GW  = 28;
    localparam int GH  = 31;
    localparam int XW  = 5;
    localparam int YW  = 5;
    localparam int DIV = 8;

    typedef struct {
        int         c;
        bit         rd;
        int         x;
        int         y;
        logic [3:0] d;
        bit         b;
        bit         mv;
    } ev_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    bit   walls [GH][GW];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   done    = 1'b0;

    int         cyc   = 0;
    int         nrun  = 0;
    bit         p_rst = 1'b1;
    bit         p_run = 1'b0;
    int         m_x   = 14;
    int         m_y   = 23;
    logic [3:0] m_dir = 4'd0;
    bit         m_blk = 1'b0;
    ev_t        evq[$];

    pacman_move_scheduler_if #(.X_W(XW), .Y_W(YW)) bus ();

    pacman_move_scheduler #(
        .GRID_W(GW), .GRID_H(GH), .START_X(14), .START_Y(23),
        .MOVE_DIV(DIV), .X_W(XW), .Y_W(YW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Neighbour of (x,y) in direction d; returns 1 when the tile is on the grid (or wrapped).
    function automatic bit nbr(input int x, input int y, input logic [3:0] d,
                               output int nx, output int ny);
        nx = x;
        ny = y;
        case (d)
            4'b1000: if (y > 0)      begin ny = y - 1; return 1'b1; end
            4'b0100: if (y < GH - 1) begin ny = y + 1; return 1'b1; end
            4'b0010: begin
                if (x > 0) begin nx = x - 1; return 1'b1; end
`ifdef TUNNEL_WRAP_EN
                nx = GW - 1;
                return 1'b1;
`endif
            end
            4'b0001: begin
                if (x < GW - 1) begin nx = x + 1; return 1'b1; end
`ifdef TUNNEL_WRAP_EN
                nx = 0;
                return 1'b1;
`endif
            end
            default: ;
        endcase
        return 1'b0;
    endfunction

    task automatic push(input int c, input bit rd, input int x, input int y,
                        input logic [3:0] d, input bit b, input bit mv);
        ev_t e;
        e.c = c; e.rd = rd; e.x = x; e.y = y; e.d = d; e.b = b; e.mv = mv;
        evq.push_back(e);
    endtask

    // Attempt a step in direction d whose query slot starts at cycle t0+1.
    task automatic try_step(input int t0, input logic [3:0] d, input logic [3:0] new_dir,
                            output bit ok);
        int nx, ny;
        bit inb;
        inb = nbr(m_x, m_y, d, nx, ny);
        ok  = inb && !walls[ny][nx];
        if (inb) push(t0 + 1, 1'b1, nx, ny, 4'd0, 1'b0, 1'b0);
        if (ok)  push(t0 + 3, 1'b0, nx, ny, new_dir, 1'b0, 1'b1);
    endtask

    // Tile-level decision for one movement tick seen at cycle t.
    task automatic schedule(input int t);
        logic [3:0] req;
        bit ok;
        req = {bus.up_req, bus.down_req, bus.left_req, bus.right_req};
        if ($countones(req) == 1 && req != m_dir) begin
            try_step(t, req, req, ok);
            if (!ok) begin
                if (m_dir != 4'd0) begin
                    try_step(t + 2, m_dir, m_dir, ok);
                    if (!ok) push(t + 5, 1'b0, m_x, m_y, m_dir, 1'b1, 1'b0);
                end else begin
                    push(t + 3, 1'b0, m_x, m_y, m_dir, 1'b1, 1'b0);
                end
            end
        end else if (m_dir != 4'd0) begin
            try_step(t, m_dir, m_dir, ok);
            if (!ok) push(t + 3, 1'b0, m_x, m_y, m_dir, 1'b1, 1'b0);
        end
    endtask

    task automatic set_req(input bit u, input bit d, input bit l, input bit r);
        bus.up_req = u; bus.down_req = d; bus.left_req = l; bus.right_req = r;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        bus.run = 1'b0;
        set_req(0, 0, 0, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        foreach (walls[i, j]) walls[i][j] = 1'b0;
    endtask

    task automatic wait_moved(input string nm, input int lim, output int w);
        int i;
        w = 0;
        i = 0;
        while (w == 0 && i < lim) begin
            @(posedge clk); #1;
            i++;
            if (bus.moved) w = i;
        end
        if (w == 0) chk({nm, "_timeout"}, 0, 1);
    endtask

    task automatic wait_rd(input string nm, input int lim);
        int  i;
        bit  seen;
        i = 0;
        seen = 1'b0;
        while (!seen && i < lim) begin
            @(posedge clk); #1;
            i++;
            if (bus.map_rd) seen = 1'b1;
        end
        if (!seen) chk({nm, "_timeout"}, 0, 1);
    endtask

    initial begin
        int w;
        int cnt;
        bus.run = 1'b0;
        set_req(0, 0, 0, 0);
        bus.map_wall = 1'b0;
        fork
            // Directed scenarios
            begin
                // 1: reset state, then idle running with no request
                do_reset();
                chk("rst_pos_x", int'(bus.pos_x), 14);
                chk("rst_pos_y", int'(bus.pos_y), 23);
                chk("rst_cur_dir", int'(bus.cur_dir), 0);
                chk("rst_moved", int'(bus.moved), 0);
                chk("rst_blocked", int'(bus.blocked), 0);
                chk("rst_map_rd", int'(bus.map_rd), 0);
                chk("rst_map_x", int'(bus.map_x), 0);
                chk("rst_map_y", int'(bus.map_y), 0);
                bus.run = 1'b1;
                cnt = 0;
                repeat (40) begin
                    @(posedge clk); #1;
                    if (bus.map_rd) cnt++;
                end
                chk("t1_map_rd_count", cnt, 0);
                chk("t1_pos_x", int'(bus.pos_x), 14);
                chk("t1_blocked", int'(bus.blocked), 0);

                // 2: straight left on an open maze
                do_reset();
                bus.run = 1'b1;
                set_req(0, 0, 1, 0);
                wait_moved("t2_first", 30, w);
                chk("t2_first_latency", w, 11);
                chk("t2_pos_x_13", int'(bus.pos_x), 13);
                chk("t2_cur_dir", int'(bus.cur_dir), 2);
                wait_moved("t2_second", 20, w);
                chk("t2_period", w, 8);
                chk("t2_pos_x_12", int'(bus.pos_x), 12);

                // 3: buffered up turn, blocked first then taken
                do_reset();
                walls[22][14] = 1'b1;
                bus.run = 1'b1;
                set_req(0, 0, 0, 1);
                wait_moved("t3_right", 30, w);
                set_req(0, 0, 1, 0);
                wait_moved("t3_left", 20, w);
                chk("t3_pos_x_14", int'(bus.pos_x), 14);
                set_req(1, 0, 0, 0);
                wait_moved("t3_fallback", 20, w);
                chk("t3_fallback_gap", w, 10);
                chk("t3_fb_pos_x", int'(bus.pos_x), 13);
                chk("t3_fb_dir", int'(bus.cur_dir), 2);
                wait_moved("t3_turn", 20, w);
                chk("t3_turn_gap", w, 6);
                chk("t3_turn_pos_x", int'(bus.pos_x), 13);
                chk("t3_turn_pos_y", int'(bus.pos_y), 22);
                chk("t3_turn_dir", int'(bus.cur_dir), 8);

                // 4: straight into a wall, then turn down
                do_reset();
                walls[23][15] = 1'b1;
                bus.run = 1'b1;
                set_req(0, 0, 1, 0);
                wait_moved("t4_left", 30, w);
                set_req(0, 0, 0, 1);
                wait_moved("t4_right", 20, w);
                idle(9);
                chk("t4_blocked", int'(bus.blocked), 1);
                chk("t4_pos_x", int'(bus.pos_x), 14);
                chk("t4_dir_kept", int'(bus.cur_dir), 1);
                set_req(0, 1, 0, 0);
                wait_moved("t4_down", 20, w);
                chk("t4_down_pos_x", int'(bus.pos_x), 14);
                chk("t4_down_pos_y", int'(bus.pos_y), 24);
                chk("t4_down_blocked", int'(bus.blocked), 0);
                chk("t4_down_dir", int'(bus.cur_dir), 4);

                // 5: left edge of the maze
                do_reset();
                bus.run = 1'b1;
                set_req(1, 0, 0, 0);
                for (int k = 0; k < 9; k++) wait_moved("t5_up", 20, w);
                chk("t5_pos_y_14", int'(bus.pos_y), 14);
                set_req(0, 0, 1, 0);
                for (int k = 0; k < 14; k++) wait_moved("t5_left", 20, w);
                chk("t5_pos_x_0", int'(bus.pos_x), 0);
                cnt = 0;
                repeat (12) begin
                    @(posedge clk); #1;
                    if (bus.map_rd) cnt++;
                end
`ifdef TUNNEL_WRAP_EN
                chk("t5_edge_map_rd", cnt, 1);
                chk("t5_edge_map_x", int'(bus.map_x), 27);
                chk("t5_edge_pos_x", int'(bus.pos_x), 27);
                chk("t5_edge_blocked", int'(bus.blocked), 0);
`else
                chk("t5_edge_map_rd", cnt, 0);
                chk("t5_edge_pos_x", int'(bus.pos_x), 0);
                chk("t5_edge_blocked", int'(bus.blocked), 1);
`endif
                chk("t5_edge_pos_y", int'(bus.pos_y), 14);

                // 6a: reset lands while an open read is being answered
                do_reset();
                bus.run = 1'b1;
                set_req(0, 0, 1, 0);
                wait_rd("t6a_qreq", 20);
                @(posedge clk); #1;
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                cnt = 0;
                repeat (4) begin
                    if (bus.moved) cnt++;
                    @(posedge clk); #1;
                end
                chk("t6a_moved_count", cnt, 0);
                chk("t6a_pos_x", int'(bus.pos_x), 14);
                chk("t6a_pos_y", int'(bus.pos_y), 23);
                chk("t6a_cur_dir", int'(bus.cur_dir), 0);

                // 6b: pause pulse during the straight query
                wait_moved("t6b_first", 30, w);
                chk("t6b_pos_x_13", int'(bus.pos_x), 13);
                wait_rd("t6b_qcur", 20);
                bus.run = 1'b0;
                @(posedge clk); #1;
                bus.run = 1'b1;
                cnt = 0;
                repeat (6) begin
                    if (bus.moved) cnt++;
                    @(posedge clk); #1;
                end
                chk("t6b_moved_count", cnt, 0);
                chk("t6b_pos_x_held", int'(bus.pos_x), 13);
                wait_moved("t6b_resume", 25, w);
                chk("t6b_pos_x_12", int'(bus.pos_x), 12);
                idle(2);
                done = 1'b1;
            end
            // Model and per-cycle comparison against the DUT outputs
            begin
                bit e_rd, e_mv;
                int ex, ey;
                while (!done) begin
                    @(negedge clk);
                    cyc++;
                    if (p_rst) begin
                        m_x = 14; m_y = 23; m_dir = 4'd0; m_blk = 1'b0;
                        evq.delete();
                        nrun = 0;
                    end else if (!p_run) begin
                        evq.delete();
                        nrun = 0;
                    end else begin
                        nrun++;
                    end
                    e_rd = 1'b0; e_mv = 1'b0; ex = 0; ey = 0;
                    for (int i = evq.size() - 1; i >= 0; i--) begin
                        if (evq[i].c == cyc) begin
                            if (evq[i].rd) begin
                                e_rd = 1'b1; ex = evq[i].x; ey = evq[i].y;
                            end else begin
                                m_x = evq[i].x; m_y = evq[i].y;
                                m_dir = evq[i].d; m_blk = evq[i].b;
                                e_mv = evq[i].mv;
                            end
                            evq.delete(i);
                        end
                    end
                    chk("mdl_pos_x", int'(bus.pos_x), m_x);
                    chk("mdl_pos_y", int'(bus.pos_y), m_y);
                    chk("mdl_cur_dir", int'(bus.cur_dir), int'(m_dir));
                    chk("mdl_blocked", int'(bus.blocked), int'(m_blk));
                    chk("mdl_moved", int'(bus.moved), int'(e_mv));
                    chk("mdl_map_rd", int'(bus.map_rd), int'(e_rd));
                    if (e_rd) begin
                        chk("mdl_map_x", int'(bus.map_x), ex);
                        chk("mdl_map_y", int'(bus.map_y), ey);
                    end
                    if (!reset && bus.run && nrun > 0 && (nrun % DIV) == 0) schedule(cyc);
                    p_rst = reset;
                    p_run = bus.run;
                end
            end
            // Synchronous-read wall memory
            begin
                bit rd;
                int mx, my;
                while (!done) begin
                    @(negedge clk);
                    rd = bus.map_rd;
                    mx = int'(bus.map_x);
                    my = int'(bus.map_y);
                    @(posedge clk); #1;
                    if (rd && mx < GW && my < GH) bus.map_wall = walls[my][mx];
                    else                          bus.map_wall = 1'b0;
                end
            end
        join
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pacman_move_scheduler.md
Name: pacman_move_scheduler

Overview:
Sequences Pac-Man's grid movement from the held one-hot user direction. On each movement tick it consults the maze wall map through a shared synchronous-read port. It applies the requested turn when that path is open, otherwise continues in the current direction, otherwise stops. It sits between the direction-hold stage and the sprite renderer/collision logic.

Parameters:
GRID_W, 28, maze width in tiles
GRID_H, 31, maze height in tiles
START_X, 14, tile column after reset
START_Y, 23, tile row after reset
MOVE_DIV, 8, clk cycles per movement tick; must be >= 8
X_W, $clog2(GRID_W), width of x coordinates
Y_W, $clog2(GRID_H), width of y coordinates

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-high
run  input  1  1 = game running; 0 = hold position, no ticks
up_req  input  1  held direction up (one-hot group with the next three)
down_req  input  1  held direction down
left_req  input  1  held direction left
right_req  input  1  held direction right
map_rd  output  1  wall-map read strobe
map_x  output  X_W  queried tile column
map_y  output  Y_W  queried tile row
map_wall  input  1  1 = queried tile is wall; valid the cycle after map_rd
pos_x  output  X_W  current tile column
pos_y  output  Y_W  current tile row
cur_dir  output  4  current motion {up,down,left,right}, one-hot or 0
moved  output  1  1-cycle pulse when position updates
blocked  output  1  1 = last tick produced no move

Behaviour:
- Reset values: pos_x=START_X, pos_y=START_Y, cur_dir=0, moved=0, blocked=0, map_rd=0, map_x=0, map_y=0; FSM=IDLE; tick counter=0; tick_pend=0.
- Request decode: req is valid only if exactly one of the four *_req inputs is high. Zero or multiple highs mean no request.
- Tick counter: runs 0..MOVE_DIV-1 while run=1. On wrap it sets tick_pend. With run=0 the counter is held at 0 and tick_pend is cleared.
- FSM states: IDLE, Q_REQ, R_REQ, Q_CUR, R_CUR.
- IDLE -> Q_REQ: tick_pend=1, req valid, req != cur_dir. Clear tick_pend.
- IDLE -> Q_CUR: tick_pend=1, cur_dir != 0, and no qualifying req. Clear tick_pend.
- IDLE, tick_pend=1, no req, cur_dir=0: clear tick_pend, stay in IDLE. blocked is unchanged.
- Q_REQ: map_rd=1; map_x/map_y = neighbour of pos in the req direction. Go to R_REQ.
- R_REQ, map_wall=0: cur_dir<=req, pos<=neighbour, moved=1 next cycle, blocked<=0. Go to IDLE.
- R_REQ, map_wall=1: if cur_dir != 0 go to Q_CUR. Otherwise blocked<=1 and go to IDLE.
- Q_CUR: map_rd=1 with the neighbour in cur_dir. Go to R_CUR.
- R_CUR, map_wall=0: pos<=neighbour, moved pulse, blocked<=0.
- R_CUR, map_wall=1: pos unchanged, cur_dir kept (facing retained), blocked<=1.
- R_CUR exits to IDLE in both cases.
- Out-of-grid neighbour (x-1 at x=0, x+1 at GRID_W-1, y-1 at y=0, y+1 at GRID_H-1): treated as a wall without issuing map_rd. The R_* decision uses wall=1 in the same slot.
- map_x/map_y hold their last value when map_rd=0.
- Latency: tick to moved is 3 cycles (requested turn or straight move) or 5 cycles (failed turn, then straight move).
- Buffered turn: a pending req that hits a wall is re-tried on every tick while it remains held. It is applied on the first tick its path is open.
- run deasserted mid-operation: FSM aborts to IDLE at the next edge, no position update, moved=0.
- reset mid-operation: all registers take their reset values at that edge, overriding any in-flight read.
- Coordinate arithmetic: unsigned at width X_W/Y_W. The boundary checks above run before any add/sub, so no wrap occurs.

Optional Feature:
TUNNEL_WRAP_EN
- Defined: horizontal moves off the grid wrap. Left from x=0 queries/moves to x=GRID_W-1; right from x=GRID_W-1 goes to x=0. map_rd is issued for the wrapped tile. Vertical out-of-grid stays a wall.
- Undefined: all out-of-grid neighbours are walls, as in Behaviour.

Test Plan:
1. Reset, then run=1, no req -> pos=(14,23), cur_dir=0, no map_rd for 40 cycles, blocked=0.
2. left_req held, no walls -> first moved 3 cycles after the first tick; pos_x 14->13->12 every 8 cycles; cur_dir=4'b0010.
3. Moving left, up_req asserted with a wall above (14,22) but open at (13,22) -> tick 1 turn fails, pos_x=13 via Q_CUR (5-cycle latency); tick 2 turn succeeds, pos=(13,22), cur_dir=4'b1000.
4. Moving right into a wall at (15,23) from (14,23) -> pos unchanged, blocked=1, cur_dir stays 4'b0001; right_req then down_req with (14,24) open -> pos=(14,24), blocked=0.
5. pos=(0,14), left_req, no walls -> without the macro: blocked=1, no map_rd. With TUNNEL_WRAP_EN: map_x=27, pos=(27,14).
6. Assert reset during R_REQ with map_wall=0 -> pos=(14,23), cur_dir=0, moved never pulses; a run=0 pulse in Q_CUR -> FSM back to IDLE, no move.
